ssd_scan_decoder: RTL and testbench
===================================

// Module: ssd_scan_decoder
// PURPOSE
//  Receive-side monitor for the 4-digit multiplexed 7-segment bus (AN/SSD) driven by the counter/display blocks.
//  Samples the scanned anode/segment lines, debounces each digit dwell and decodes the glyph back to a hex nibble.
//  Assembles complete 4-digit frames into a 16-bit word for self-checking benches and on-board loopback.
// PARAMETERS
//  STABLE_CYCLES  4     consecutive identical {AN,SSD} samples required to accept a digit (>=2)
//  FRAME_TIMEOUT  1024  cycles without any accepted digit before a partial frame is discarded
// PORTS
//  clk         in   1   rising-edge clock
//  Reset       in   1   synchronous, active-high reset
//  AN          in   4   anode enables, active-low; AN[i]=0 selects digit i (digit 0 = least significant)
//  SSD         in   7   segments, active-low, SSD[6:0] = {g,f,e,d,c,b,a}
//  value       out  16  last complete frame {d3,d2,d1,d0}
//  digit_vld   out  4   digit i captured in the frame currently being collected
//  frame_done  out  1   1-cycle pulse: value just updated
//  seg_err     out  1   1-cycle pulse: stable dwell with an undecodable segment pattern
//  an_err      out  1   1-cycle pulse: stable dwell with more than one anode low
//  timeout     out  1   1-cycle pulse: partial frame discarded
// BEHAVIOUR
//  - Reset: value=0, digit_vld=0, all pulses 0, stability counter=0, timeout counter=0, state IDLE.
//    Reset asserted mid-operation discards any partial frame; it takes priority over every other event.
//  - Sampling: AN/SSD are registered once (in_q). stab_cnt counts consecutive edges with the same {AN,SSD} pair.
//    A change reloads stab_cnt to 1. stab_cnt saturates at STABLE_CYCLES.
//  - Acceptance: fires exactly once per dwell, on the edge at which stab_cnt reaches STABLE_CYCLES.
//    A pair presented before edge k is accepted at edge k+STABLE_CYCLES (one edge for in_q).
//  - AN=4'b1111 (blanking) is never accepted and raises no error.
//  - Multiple anodes low: an_err pulse; nothing is written.
//  - Decode table (SSD -> nibble): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9
//    08->A 03->b 46->C 21->d 06->E 0E->F (hex, 7-bit). Any other pattern: seg_err pulse; nothing written.
//  - Valid accept of digit i: nibble i of the collect buffer is written and digit_vld[i] is set.
//    Re-accepting an already-valid digit overwrites it.
//  - Frame completion: on the accept edge that makes digit_vld==4'b1111, value <= buffer (including the new nibble).
//    On the same edge, frame_done=1 and digit_vld <= 0. value is never updated with a partial frame.
//  - FSM: IDLE (digit_vld==0) -> COLLECT on the first valid accept.
//    COLLECT -> IDLE on frame completion, or on timeout.
//  - Timeout: in COLLECT, to_cnt counts edges since the last valid accept. When it reaches FRAME_TIMEOUT-1:
//    digit_vld<=0, timeout=1, state -> IDLE. to_cnt clears on every valid accept; it is held at 0 in IDLE.
//  - Simultaneous events: a completion accept on the timeout edge wins (frame_done=1, timeout=0).
//  - Errors do not clear digit_vld and do not reset to_cnt.
// TESTING (bench uses STABLE_CYCLES=2, FRAME_TIMEOUT=16)
//  1 Reset 2 cycles -> value=0000, digit_vld=0, no pulses.
//  2 Scan digits 0..3 with patterns 30,02,08,40, dwell 4 cycles each
//    -> after the 4th accept: value=16'h0A63, frame_done exactly one cycle, digit_vld=0.
//  3 Dwell SSD=7'h7F on AN=1110 -> seg_err once per dwell; digit_vld unchanged.
//    Dwell AN=1100 -> an_err once per dwell; nothing written.
//  4 Accept digits 0,1, then hold AN=1111 for 20 cycles -> timeout pulse 16 cycles after the last accept;
//    digit_vld=0; value unchanged.
//  5 Glitch: AN=1101 for 1 cycle between dwells -> no accept. Same pair held 10 cycles -> exactly one accept.
//  6 Assert Reset after 3 accepted digits -> digit_vld=0, value=0; a following full scan of 1,2,3,4 -> value=16'h4321.

Source files
------------

// File: rtl/ssd_scan_decoder.sv
// Monitor for a scanned 4-digit 7-segment bus: debounces each digit dwell, decodes it to a nibble and collects frames.
// Latency: a pair held from edge k is accepted at edge k+STABLE_CYCLES; value/frame_done follow on the completing accept.
// Backpressure: none; the bus is observed passively and every accept/error is reported as a single-cycle pulse.
//
// Ports:
//   clk        rising-edge clock
//   Reset      synchronous active-high reset
//   AN[3:0]    anode enables, active-low, AN[i]=0 selects digit i (digit 0 least significant)
//   SSD[6:0]   segments, active-low, {g,f,e,d,c,b,a}
//   value      last complete frame {d3,d2,d1,d0}
//   digit_vld  digits captured so far in the frame being collected
//   frame_done pulse: value just updated
//   seg_err    pulse: stable dwell carrying an undecodable glyph
//   an_err     pulse: stable dwell with more than one anode low
//   timeout    pulse: partial frame discarded

module ssd_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FRAME_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [3:0]  AN,
    input  logic [6:0]  SSD,
    output logic [15:0] value,
    output logic [3:0]  digit_vld,
    output logic        frame_done,
    output logic        seg_err,
    output logic        an_err,
    output logic        timeout
);

    localparam int              SW         = $clog2(STABLE_CYCLES + 1);
    localparam int              TW         = $clog2(FRAME_TIMEOUT);
    localparam logic [SW-1:0]   STAB_MAX   = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0]   STAB_PRE   = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]   TO_MAX     = TW'(FRAME_TIMEOUT - 1);
    // All anodes off, all segments off: the bus at rest.
    localparam logic [10:0]     BLANK_PAIR = 11'h7FF;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t          state;
    logic [10:0]     in_q;      // registered {AN,SSD}
    logic [10:0]     pair_q;    // pair the stability counter refers to
    logic [SW-1:0]   stab_cnt;
    logic [TW-1:0]   to_cnt;
    logic [15:0]     col_q;     // collect buffer for the frame in progress

    logic            same;
    logic            accept;
    logic            blank;
    logic            multi;
    logic            dec_ok;
    logic            valid_acc;
    logic            complete;
    logic [3:0]      an_sel;
    logic [3:0]      dec_nib;
    logic [3:0]      next_vld;
    logic [15:0]     next_col;

    // Returns {ok, nibble}; ok=0 for any glyph outside the hex set.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        same      = (in_q == pair_q);
        // Fires only on the edge the counter steps from STABLE-1 to STABLE,
        // so a long dwell produces exactly one accept.
        accept    = same && (stab_cnt == STAB_PRE);
        an_sel    = ~pair_q[10:7];
        blank     = (an_sel == 4'b0000);
        // More than one bit set iff clearing the lowest set bit leaves something.
        multi     = |(an_sel & (an_sel - 4'd1));
        {dec_ok, dec_nib} = seg_decode(pair_q[6:0]);
        valid_acc = accept && !blank && !multi && dec_ok;
        // an_sel is one-hot whenever valid_acc is true.
        next_vld  = digit_vld | an_sel;
        next_col  = col_q;
        for (int i = 0; i < 4; i++) begin
            if (an_sel[i]) begin
                next_col[4*i +: 4] = dec_nib;
            end
        end
        complete  = valid_acc && (next_vld == 4'hF);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state      <= IDLE;
            in_q       <= BLANK_PAIR;
            pair_q     <= BLANK_PAIR;
            stab_cnt   <= '0;
            to_cnt     <= '0;
            col_q      <= '0;
            value      <= '0;
            digit_vld  <= '0;
            frame_done <= 1'b0;
            seg_err    <= 1'b0;
            an_err     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            in_q <= {AN, SSD};

            if (!same) begin
                pair_q   <= in_q;
                stab_cnt <= SW'(1);
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + SW'(1);
            end

            frame_done <= 1'b0;
            timeout    <= 1'b0;
            an_err     <= accept && multi;
            seg_err    <= accept && !blank && !multi && !dec_ok;

            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (valid_acc) begin
                        col_q     <= next_col;
                        digit_vld <= next_vld;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    // A valid accept (including a completing one) takes
                    // precedence over an expiring timer on the same edge.
                    if (valid_acc) begin
                        col_q  <= next_col;
                        to_cnt <= '0;
                        if (complete) begin
                            value      <= next_col;
                            digit_vld  <= '0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            digit_vld <= next_vld;
                        end
                    end else if (to_cnt == TO_MAX) begin
                        digit_vld <= '0;
                        timeout   <= 1'b1;
                        to_cnt    <= '0;
                        state     <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed scenarios plus randomized bus traffic against a behavioural model.
// Latency: model predicts outputs one edge after the input pair is sampled (the input register).
// Backpressure: none; stimulus is a per-cycle queue of {AN,SSD} pairs.

module tb_ssd_scan_decoder;

    localparam int S  = 2;
    localparam int FT = 16;

    logic        clk = 1'b0;
    logic        Reset;
    logic [3:0]  AN;
    logic [6:0]  SSD;
    logic [15:0] value;
    logic [3:0]  digit_vld;
    logic        frame_done;
    logic        seg_err;
    logic        an_err;
    logic        timeout;

    always #5 clk = ~clk;

    ssd_scan_decoder #(
        .STABLE_CYCLES (S),
        .FRAME_TIMEOUT (FT)
    ) dut (
        .clk        (clk),
        .Reset      (Reset),
        .AN         (AN),
        .SSD        (SSD),
        .value      (value),
        .digit_vld  (digit_vld),
        .frame_done (frame_done),
        .seg_err    (seg_err),
        .an_err     (an_err),
        .timeout    (timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0]  pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Behavioural model state.
    logic [10:0] m_last;
    int          m_run;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_vld;
    logic [15:0] m_value;
    int          m_edge;
    int          m_last_acc;
    bit          m_collect;
    logic        m_fd, m_se, m_ae, m_to;

    logic [10:0] prev_p;
    logic [10:0] stim [$];

    function automatic void model_reset();
        m_last    = 11'h7FF;
        m_run     = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_vld     = 4'h0;
        m_value   = 16'h0;
        m_edge    = 0;
        m_last_acc = 0;
        m_collect = 1'b0;
        m_fd = 0; m_se = 0; m_ae = 0; m_to = 0;
        prev_p    = 11'h7FF;
    endfunction

    // Effect of the pair sampled at one edge, as seen after the following edge.
    function automatic void model_step(input logic [10:0] p);
        int  lows;
        int  dig;
        int  nib;
        bit  acc;
        m_fd = 0; m_se = 0; m_ae = 0; m_to = 0;
        acc  = 0;
        m_edge++;
        if (p == m_last) m_run++;
        else begin
            m_last = p;
            m_run  = 1;
        end
        if (m_run == S) begin
            lows = 0;
            dig  = 0;
            for (int i = 0; i < 4; i++) if (!p[7+i]) begin lows++; dig = i; end
            if (lows > 1) m_ae = 1;
            else if (lows == 1) begin
                nib = -1;
                for (int j = 0; j < 16; j++) if (pat[j] == p[6:0]) nib = j;
                if (nib < 0) m_se = 1;
                else begin
                    acc = 1;
                    m_nib[dig] = 4'(nib);
                    m_vld[dig] = 1'b1;
                    m_last_acc = m_edge;
                    if (m_vld == 4'hF) begin
                        m_value   = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
                        m_vld     = 4'h0;
                        m_fd      = 1;
                        m_collect = 0;
                    end else m_collect = 1;
                end
            end
        end
        if (!acc && m_collect && (m_edge - m_last_acc == FT)) begin
            m_vld     = 4'h0;
            m_to      = 1;
            m_collect = 0;
        end
    endfunction

    function automatic logic [3:0] digit_an(input int i);
        logic [3:0] t;
        t = 4'b0001 << i;
        return ~t;
    endfunction

    task automatic push(input logic [3:0] an, input logic [6:0] ssd, input int n);
        repeat (n) stim.push_back({an, ssd});
    endtask

    task automatic cycle(input logic [10:0] p);
        AN  = p[10:7];
        SSD = p[6:0];
        @(posedge clk);
        #1;
        model_step(prev_p);
        prev_p = p;
    endtask

    task automatic do_reset(input int cycles, input logic [3:0] an, input logic [6:0] ssd);
        Reset = 1'b1;
        AN    = an;
        SSD   = ssd;
        repeat (cycles) @(posedge clk);
        #1;
        Reset = 1'b0;
        AN    = 4'hF;
        SSD   = 7'h7F;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(2, 4'($urandom), 7'($urandom));
        n_cmp++;
        if (value !== 16'h0000) begin n_bad++; $display("FAIL reset_value: got %h want 0000", value); end
        n_cmp++;
        if (digit_vld !== 4'h0) begin n_bad++; $display("FAIL reset_vld: got %b want 0000", digit_vld); end
        n_cmp++;
        if ({frame_done, seg_err, an_err, timeout} !== 4'b0000)
            begin n_bad++; $display("FAIL reset_pulses: got %b want 0000", {frame_done, seg_err, an_err, timeout}); end
        stim.delete();
        push(4'hF, 7'h7F, 3);
        foreach (stim[i]) begin
            cycle(stim[i]);
            n_cmp++;
            if ({value, digit_vld, frame_done, seg_err, an_err, timeout} !== {m_value, m_vld, m_fd, m_se, m_ae, m_to})
                begin n_bad++; $display("FAIL reset_idle step %0d: got %h want %h", i,
                    {value, digit_vld, frame_done, seg_err, an_err, timeout}, {m_value, m_vld, m_fd, m_se, m_ae, m_to}); end
        end
    endtask

    task automatic test_scan();
        int fd_cnt = 0;
        do_reset(2, 4'hF, 7'h7F);
        stim.delete();
        push(digit_an(0), 7'h30, 4);
        push(digit_an(1), 7'h02, 4);
        push(digit_an(2), 7'h08, 4);
        push(digit_an(3), 7'h40, 4);
        push(4'hF, 7'h7F, 3);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (frame_done === 1'b1) fd_cnt++;
            n_cmp++;
            if ({value, digit_vld, frame_done, seg_err, an_err, timeout} !== {m_value, m_vld, m_fd, m_se, m_ae, m_to})
                begin n_bad++; $display("FAIL scan step %0d: got %h want %h", i,
                    {value, digit_vld, frame_done, seg_err, an_err, timeout}, {m_value, m_vld, m_fd, m_se, m_ae, m_to}); end
        end
        n_cmp++;
        if (value !== 16'h0A63) begin n_bad++; $display("FAIL scan_value: got %h want 0a63", value); end
        n_cmp++;
        if (fd_cnt != 1) begin n_bad++; $display("FAIL scan_done_count: got %0d want 1", fd_cnt); end
        n_cmp++;
        if (digit_vld !== 4'h0) begin n_bad++; $display("FAIL scan_vld: got %b want 0000", digit_vld); end
    endtask

    task automatic test_errors();
        int se_cnt = 0;
        int ae_cnt = 0;
        do_reset(2, 4'hF, 7'h7F);
        stim.delete();
        push(digit_an(0), 7'h30, 4);
        push(4'b1110, 7'h7F, 3);
        push(4'hF, 7'h7F, 1);
        push(4'b1110, 7'h7F, 3);
        push(4'b1100, 7'h30, 3);
        push(4'hF, 7'h7F, 1);
        push(4'b1100, 7'h30, 3);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (seg_err === 1'b1) se_cnt++;
            if (an_err === 1'b1) ae_cnt++;
            n_cmp++;
            if ({value, digit_vld, frame_done, seg_err, an_err, timeout} !== {m_value, m_vld, m_fd, m_se, m_ae, m_to})
                begin n_bad++; $display("FAIL errors step %0d: got %h want %h", i,
                    {value, digit_vld, frame_done, seg_err, an_err, timeout}, {m_value, m_vld, m_fd, m_se, m_ae, m_to}); end
        end
        n_cmp++;
        if (se_cnt != 2) begin n_bad++; $display("FAIL seg_err_count: got %0d want 2", se_cnt); end
        n_cmp++;
        if (ae_cnt != 2) begin n_bad++; $display("FAIL an_err_count: got %0d want 2", ae_cnt); end
        n_cmp++;
        if (digit_vld !== 4'b0001) begin n_bad++; $display("FAIL errors_vld: got %b want 0001", digit_vld); end
    endtask

    task automatic test_timeout();
        int t_acc = -1;
        int t_to  = -1;
        int to_n  = 0;
        do_reset(2, 4'hF, 7'h7F);
        stim.delete();
        push(digit_an(0), 7'h79, 4);
        push(digit_an(1), 7'h12, 4);
        push(4'hF, 7'h7F, 20);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (t_acc < 0 && digit_vld === 4'b0011) t_acc = i;
            if (timeout === 1'b1) begin to_n++; t_to = i; end
            n_cmp++;
            if ({value, digit_vld, frame_done, seg_err, an_err, timeout} !== {m_value, m_vld, m_fd, m_se, m_ae, m_to})
                begin n_bad++; $display("FAIL timeout step %0d: got %h want %h", i,
                    {value, digit_vld, frame_done, seg_err, an_err, timeout}, {m_value, m_vld, m_fd, m_se, m_ae, m_to}); end
        end
        n_cmp++;
        if (to_n != 1) begin n_bad++; $display("FAIL timeout_count: got %0d want 1", to_n); end
        n_cmp++;
        if (t_acc < 0 || t_to - t_acc != FT)
            begin n_bad++; $display("FAIL timeout_delay: got %0d want %0d", t_to - t_acc, FT); end
        n_cmp++;
        if (digit_vld !== 4'h0 || value !== 16'h0000)
            begin n_bad++; $display("FAIL timeout_state: got vld=%b value=%h want 0000/0000", digit_vld, value); end
    endtask

    task automatic test_glitch();
        int fd_cnt = 0;
        do_reset(2, 4'hF, 7'h7F);
        stim.delete();
        push(digit_an(0), 7'h24, 4);
        push(digit_an(1), 7'h19, 4);
        push(digit_an(2), 7'h12, 4);
        push(4'b1101, 7'h00, 1);
        push(digit_an(3), 7'h78, 10);
        push(4'hF, 7'h7F, 2);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (frame_done === 1'b1) fd_cnt++;
            n_cmp++;
            if ({value, digit_vld, frame_done, seg_err, an_err, timeout} !== {m_value, m_vld, m_fd, m_se, m_ae, m_to})
                begin n_bad++; $display("FAIL glitch step %0d: got %h want %h", i,
                    {value, digit_vld, frame_done, seg_err, an_err, timeout}, {m_value, m_vld, m_fd, m_se, m_ae, m_to}); end
        end
        n_cmp++;
        if (value !== 16'h7542) begin n_bad++; $display("FAIL glitch_value: got %h want 7542", value); end
        n_cmp++;
        if (fd_cnt != 1) begin n_bad++; $display("FAIL glitch_done_count: got %0d want 1", fd_cnt); end
        n_cmp++;
        if (digit_vld !== 4'h0) begin n_bad++; $display("FAIL glitch_single_accept: got vld=%b want 0000", digit_vld); end
    endtask

    task automatic test_reset_mid();
        int fd_cnt = 0;
        do_reset(2, 4'hF, 7'h7F);
        stim.delete();
        push(digit_an(0), 7'h12, 3);
        push(digit_an(1), 7'h02, 3);
        push(digit_an(2), 7'h78, 3);
        push(digit_an(3), 7'h00, 3);
        push(4'hF, 7'h7F, 1);
        push(digit_an(0), 7'h10, 3);
        push(digit_an(1), 7'h08, 3);
        push(digit_an(2), 7'h03, 3);
        foreach (stim[i]) begin
            cycle(stim[i]);
            n_cmp++;
            if ({value, digit_vld, frame_done, seg_err, an_err, timeout} !== {m_value, m_vld, m_fd, m_se, m_ae, m_to})
                begin n_bad++; $display("FAIL midreset_pre step %0d: got %h want %h", i,
                    {value, digit_vld, frame_done, seg_err, an_err, timeout}, {m_value, m_vld, m_fd, m_se, m_ae, m_to}); end
        end
        n_cmp++;
        if (value !== 16'h8765 || digit_vld !== 4'b0111)
            begin n_bad++; $display("FAIL midreset_before: got value=%h vld=%b want 8765/0111", value, digit_vld); end
        // Digit 3 on the bus while Reset is high must not complete the frame.
        do_reset(1, digit_an(3), 7'h02);
        n_cmp++;
        if (value !== 16'h0000 || digit_vld !== 4'h0)
            begin n_bad++; $display("FAIL midreset_after: got value=%h vld=%b want 0000/0000", value, digit_vld); end
        stim.delete();
        push(digit_an(0), 7'h79, 3);
        push(digit_an(1), 7'h24, 3);
        push(digit_an(2), 7'h30, 3);
        push(digit_an(3), 7'h19, 3);
        push(4'hF, 7'h7F, 2);
        foreach (stim[i]) begin
            cycle(stim[i]);
            if (frame_done === 1'b1) fd_cnt++;
            n_cmp++;
            if ({value, digit_vld, frame_done, seg_err, an_err, timeout} !== {m_value, m_vld, m_fd, m_se, m_ae, m_to})
                begin n_bad++; $display("FAIL midreset_post step %0d: got %h want %h", i,
                    {value, digit_vld, frame_done, seg_err, an_err, timeout}, {m_value, m_vld, m_fd, m_se, m_ae, m_to}); end
        end
        n_cmp++;
        if (value !== 16'h4321) begin n_bad++; $display("FAIL midreset_value: got %h want 4321", value); end
        n_cmp++;
        if (fd_cnt != 1) begin n_bad++; $display("FAIL midreset_done_count: got %0d want 1", fd_cnt); end
    endtask

    task automatic test_random();
        int r;
        do_reset(2, 4'hF, 7'h7F);
        for (int it = 0; it < 2500; it++) begin
            stim.delete();
            r = $urandom_range(0, 99);
            if (r < 70)
                push(digit_an($urandom_range(0, 3)), pat[$urandom_range(0, 15)], $urandom_range(1, 5));
            else if (r < 80)
                push(digit_an($urandom_range(0, 3)), 7'($urandom), $urandom_range(1, 4));
            else if (r < 88)
                push(4'($urandom), 7'($urandom), $urandom_range(1, 4));
            else
                push(4'hF, 7'h7F, $urandom_range(1, 20));
            foreach (stim[i]) begin
                cycle(stim[i]);
                n_cmp++;
                if ({value, digit_vld, frame_done, seg_err, an_err, timeout} !== {m_value, m_vld, m_fd, m_se, m_ae, m_to})
                    begin n_bad++; $display("FAIL random it %0d: got %h want %h", it,
                        {value, digit_vld, frame_done, seg_err, an_err, timeout}, {m_value, m_vld, m_fd, m_se, m_ae, m_to}); end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        AN    = 4'hF;
        SSD   = 7'h7F;
        model_reset();
        test_reset();
        test_scan();
        test_errors();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
